// File: rtl/sprite_loader.sv
// Byte-stream sprite uploader: a 'F'/'C' header selects the memory, then pixels
// arrive as HI/LO byte pairs, and a trailing XOR checksum byte closes the frame.
module sprite_loader #(
  parameter int TILE_SIZE      = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Write_En,
  output logic                  o_Sprite_Sel,
  output logic [ADDR_WIDTH-1:0] o_Write_Addr,
  output logic [8:0]            o_Write_Data,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Error
);

  localparam int N  = TILE_SIZE * TILE_SIZE;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]         TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX  = ADDR_WIDTH'(N - 1);
  localparam logic [7:0]            HDR_FROG    = 8'h46;
  localparam logic [7:0]            HDR_CAR     = 8'h43;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  function automatic logic [7:0] f_xor_accum(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                r_state;
  logic                  r_sel;
  logic                  r_hi;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [7:0]            r_cksum;
  logic [TW-1:0]         r_timer;
  logic                  r_write_en;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [8:0]            r_write_data;
  logic                  r_done;
  logic                  r_error;

  state_t                w_state;
  logic                  w_sel;
  logic                  w_hi;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [7:0]            w_cksum;
  logic [TW-1:0]         w_timer;
  logic                  w_write_en;
  logic [ADDR_WIDTH-1:0] w_write_addr;
  logic [8:0]            w_write_data;
  logic                  w_done;
  logic                  w_error;
  logic                  w_timeout;

  // Next-state and next-output logic for the upload FSM.
  always_comb begin
    w_state      = r_state;
    w_sel        = r_sel;
    w_hi         = r_hi;
    w_index      = r_index;
    w_cksum      = r_cksum;
    w_timer      = r_timer;
    w_write_en   = 1'b0;
    w_write_addr = r_write_addr;
    w_write_data = r_write_data;
    w_done       = 1'b0;
    w_error      = r_error;
    w_timeout    = (r_timer == TIMER_LIMIT);

    case (r_state)
      S_IDLE: begin
        w_timer = '0;
        if (i_Rx_DV && ((i_Rx_Byte == HDR_FROG) || (i_Rx_Byte == HDR_CAR))) begin
          w_sel   = (i_Rx_Byte == HDR_CAR);
          w_state = S_HI;
          w_error = 1'b0;
          w_index = '0;
          w_cksum = 8'h00;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_HI: begin
        if (i_Rx_DV) begin
          w_hi    = i_Rx_Byte[0];
          w_cksum = f_xor_accum(r_cksum, i_Rx_Byte);
          w_timer = '0;
          w_state = S_LO;
        end else if (w_timeout) begin
          w_error = 1'b1;
          w_timer = '0;
          w_state = S_IDLE;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_LO: begin
        if (i_Rx_DV) begin
          w_write_en   = 1'b1;
          w_write_addr = r_index;
          w_write_data = {r_hi, i_Rx_Byte};
          w_cksum      = f_xor_accum(r_cksum, i_Rx_Byte);
          w_index      = r_index + ADDR_WIDTH'(1);
          w_timer      = '0;
          w_state      = (r_index == LAST_INDEX) ? S_CHK : S_HI;
        end else if (w_timeout) begin
          w_error = 1'b1;
          w_timer = '0;
          w_state = S_IDLE;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == r_cksum) begin
            w_done = 1'b1;
          end else begin
            w_error = 1'b1;
          end
          w_timer = '0;
          w_state = S_IDLE;
        end else if (w_timeout) begin
          w_error = 1'b1;
          w_timer = '0;
          w_state = S_IDLE;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      default: begin
        w_timer = '0;
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_hi         <= 1'b0;
      r_index      <= '0;
      r_cksum      <= 8'h00;
      r_timer      <= '0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= 9'h000;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_sel        <= w_sel;
      r_hi         <= w_hi;
      r_index      <= w_index;
      r_cksum      <= w_cksum;
      r_timer      <= w_timer;
      r_write_en   <= w_write_en;
      r_write_addr <= w_write_addr;
      r_write_data <= w_write_data;
      r_done       <= w_done;
      r_error      <= w_error;
    end
  end

  // A strobe already registered is still blocked while reset is asserted.
  assign o_Write_En   = r_write_en & ~i_Reset;
  assign o_Sprite_Sel = r_sel;
  assign o_Write_Addr = r_write_addr;
  assign o_Write_Data = r_write_data;
  assign o_Busy       = (r_state != S_IDLE);
  assign o_Done       = r_done;
  assign o_Error      = r_error;

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: expected writes are queued as pixels are
// sent and checked by a negedge monitor; each task checks its own scenario.
module tb_sprite_loader;

  localparam int TO = 40;
  localparam int N  = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] rx;
  logic       o_Write_En, o_Sprite_Sel, o_Busy, o_Done, o_Error;
  logic [9:0] o_Write_Addr;
  logic [8:0] o_Write_Data;

  int n_cmp = 0;
  int n_mis = 0;
  int n_writes = 0;
  int n_done = 0;
  logic [19:0] exp_q[$];
  logic        exp_sel;
  logic [7:0]  cks;

  sprite_loader #(.TILE_SIZE(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(TO)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx),
    .o_Write_En(o_Write_En), .o_Sprite_Sel(o_Sprite_Sel),
    .o_Write_Addr(o_Write_Addr), .o_Write_Data(o_Write_Data),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Error(o_Error)
  );

  always #5 clk = ~clk;

  // Write monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [19:0] exp;
    if (o_Done === 1'b1) n_done++;
    if (o_Write_En === 1'b1) begin
      n_writes++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_write: got sel=%0d addr=%0d data=%h, required no write",
                 o_Sprite_Sel, o_Write_Addr, o_Write_Data);
      end else begin
        exp = exp_q.pop_front();
        if ({o_Sprite_Sel, o_Write_Addr, o_Write_Data} !== exp) begin
          n_mis++;
          $display("FAIL write: got sel=%0d addr=%0d data=%h, required sel=%0d addr=%0d data=%h",
                   o_Sprite_Sel, o_Write_Addr, o_Write_Data, exp[19], exp[18:9], exp[8:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    dv = 1'b1;
    rx = b;
    @(posedge clk);
    #1;
    dv = 1'b0;
    rx = 8'h00;
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input int addr, input bit push);
    if (push) exp_q.push_back({exp_sel, addr[9:0], hi[0], lo});
    cks = cks ^ hi ^ lo;
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic upload(input logic [7:0] hdr, input logic [7:0] mask, input bit special);
    logic [8:0] p;
    exp_sel = (hdr == 8'h43);
    cks = 8'h00;
    send_byte(hdr);
    for (int k = 0; k < N; k++) begin
      p = k[8:0];
      if (special && k == 0) send_pixel(8'hFF, 8'h5A, k, 1'b1);
      else                   send_pixel({7'b0, p[8]}, p[7:0], k, 1'b1);
    end
    send_byte(cks ^ mask);
  endtask

  task automatic test_reset();
    rst = 1'b1; dv = 1'b0; rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_Write_En, o_Sprite_Sel, o_Write_Addr, o_Write_Data, o_Busy, o_Done, o_Error} !== 23'h0) begin
      n_mis++;
      $display("FAIL reset_outputs: got we=%b sel=%b addr=%0d data=%h busy=%b done=%b err=%b, required all 0",
               o_Write_En, o_Sprite_Sel, o_Write_Addr, o_Write_Data, o_Busy, o_Done, o_Error);
    end
    rst = 1'b0;
  endtask

  task automatic test_frog_upload();
    int w0 = n_writes;
    int d0 = n_done;
    upload(8'h46, 8'h00, 1'b0);
    n_cmp++; if (o_Done !== 1'b1) begin n_mis++; $display("FAIL frog_done: got %b, required 1", o_Done); end
    n_cmp++; if (o_Error !== 1'b0) begin n_mis++; $display("FAIL frog_error: got %b, required 0", o_Error); end
    n_cmp++; if (o_Busy !== 1'b0) begin n_mis++; $display("FAIL frog_busy: got %b, required 0", o_Busy); end
    n_cmp++; if (o_Sprite_Sel !== 1'b0) begin n_mis++; $display("FAIL frog_sel: got %b, required 0", o_Sprite_Sel); end
    n_cmp++; if (n_writes - w0 != N) begin n_mis++; $display("FAIL frog_writes: got %0d, required %0d", n_writes - w0, N); end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL frog_pending: got %0d, required 0", exp_q.size()); end
    @(posedge clk); #1;
    n_cmp++; if (o_Done !== 1'b0) begin n_mis++; $display("FAIL frog_done_pulse: got %b, required 0", o_Done); end
    n_cmp++; if (n_done - d0 != 1) begin n_mis++; $display("FAIL frog_done_count: got %0d, required 1", n_done - d0); end
  endtask

  task automatic test_bad_checksum();
    int w0 = n_writes;
    int d0 = n_done;
    upload(8'h43, 8'h01, 1'b0);
    n_cmp++; if (o_Error !== 1'b1) begin n_mis++; $display("FAIL car_error: got %b, required 1", o_Error); end
    n_cmp++; if (o_Done !== 1'b0) begin n_mis++; $display("FAIL car_done: got %b, required 0", o_Done); end
    n_cmp++; if (o_Busy !== 1'b0) begin n_mis++; $display("FAIL car_busy: got %b, required 0", o_Busy); end
    n_cmp++; if (o_Sprite_Sel !== 1'b1) begin n_mis++; $display("FAIL car_sel: got %b, required 1", o_Sprite_Sel); end
    n_cmp++; if (n_writes - w0 != N) begin n_mis++; $display("FAIL car_writes: got %0d, required %0d", n_writes - w0, N); end
    @(posedge clk); #1;
    n_cmp++; if (n_done != d0) begin n_mis++; $display("FAIL car_no_done: got %0d pulses, required 0", n_done - d0); end
    exp_sel = 1'b0;
    cks = 8'h00;
    send_byte(8'h46);
    n_cmp++; if (o_Error !== 1'b0) begin n_mis++; $display("FAIL header_clears_error: got %b, required 0", o_Error); end
    n_cmp++; if (o_Busy !== 1'b1) begin n_mis++; $display("FAIL header_busy: got %b, required 1", o_Busy); end
    n_cmp++; if (o_Sprite_Sel !== 1'b0) begin n_mis++; $display("FAIL header_sel: got %b, required 0", o_Sprite_Sel); end
  endtask

  // Continues the 'F' frame opened at the end of test_bad_checksum.
  task automatic test_timeout();
    int w0 = n_writes;
    send_pixel(8'h01, 8'hA3, 0, 1'b1);
    send_pixel(8'h00, 8'h55, 1, 1'b1);
    send_pixel(8'h01, 8'h00, 2, 1'b1);
    repeat (TO - 1) @(posedge clk);
    #1;
    n_cmp++; if (o_Error !== 1'b0) begin n_mis++; $display("FAIL timeout_early_error: got %b, required 0", o_Error); end
    n_cmp++; if (o_Busy !== 1'b1) begin n_mis++; $display("FAIL timeout_early_busy: got %b, required 1", o_Busy); end
    @(posedge clk); #1;
    n_cmp++; if (o_Error !== 1'b1) begin n_mis++; $display("FAIL timeout_error: got %b, required 1", o_Error); end
    n_cmp++; if (o_Busy !== 1'b0) begin n_mis++; $display("FAIL timeout_busy: got %b, required 0", o_Busy); end
    n_cmp++; if (n_writes - w0 != 3) begin n_mis++; $display("FAIL timeout_writes: got %0d, required 3", n_writes - w0); end
    send_byte(8'h00);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (n_writes - w0 != 3) begin n_mis++; $display("FAIL timeout_late_byte: got %0d writes, required 3", n_writes - w0); end
  endtask

  task automatic test_idle_bytes();
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h41};
    int w0 = n_writes;
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i]);
      n_cmp++; if (o_Busy !== 1'b0) begin n_mis++; $display("FAIL idle_busy: byte %h got %b, required 0", bytes[i], o_Busy); end
      n_cmp++; if (o_Error !== 1'b1) begin n_mis++; $display("FAIL idle_error: byte %h got %b, required 1", bytes[i], o_Error); end
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (n_writes != w0) begin n_mis++; $display("FAIL idle_writes: got %0d, required 0", n_writes - w0); end
  endtask

  task automatic test_hi_ignored_bits();
    upload(8'h46, 8'h00, 1'b1);
    n_cmp++; if (o_Done !== 1'b1) begin n_mis++; $display("FAIL hi_ff_done: got %b, required 1", o_Done); end
    n_cmp++; if (o_Error !== 1'b0) begin n_mis++; $display("FAIL hi_ff_error: got %b, required 0", o_Error); end
  endtask

  task automatic test_reset_midway();
    int w0;
    logic [8:0] p;
    exp_sel = 1'b0;
    cks = 8'h00;
    send_byte(8'h46);
    w0 = n_writes;
    for (int k = 0; k < 500; k++) begin
      p = k[8:0];
      send_pixel({7'b0, p[8]}, p[7:0], k, k < 499);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({o_Write_En, o_Sprite_Sel, o_Write_Addr, o_Write_Data, o_Busy, o_Done, o_Error} !== 23'h0) begin
      n_mis++;
      $display("FAIL midreset_outputs: got we=%b sel=%b addr=%0d data=%h busy=%b done=%b err=%b, required all 0",
               o_Write_En, o_Sprite_Sel, o_Write_Addr, o_Write_Data, o_Busy, o_Done, o_Error);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (n_writes - w0 != 499) begin n_mis++; $display("FAIL midreset_writes: got %0d, required 499", n_writes - w0); end
    upload(8'h46, 8'h00, 1'b0);
    n_cmp++; if (o_Done !== 1'b1) begin n_mis++; $display("FAIL midreset_reupload_done: got %b, required 1", o_Done); end
    n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL midreset_pending: got %0d, required 0", exp_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dv = 1'b0;
    rx = 8'h00;
    exp_sel = 1'b0;
    cks = 8'h00;
    test_reset();
    test_frog_upload();
    test_bad_checksum();
    test_timeout();
    test_idle_bytes();
    test_hi_ignored_bits();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
